// File: rtl/quad_pkg.sv
// Shared constants and types for the quadrature step generator.
package quad_pkg;

    localparam int unsigned PHASE_CYC_DEFAULT = 24000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2
    } state_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/quad_if.sv
// Step-request and quadrature-output bundle between a requester and quad_gen.
interface quad_if #(
    parameter int unsigned PEND_W = 8
);
    logic                     l_req;
    logic                     r_req;
    logic                     en;
    logic                     clr;
    logic                     key_a;
    logic                     key_b;
    logic                     busy;
    logic signed [PEND_W-1:0] pend;

    modport master (
        output l_req, r_req, en, clr,
        input  key_a, key_b, busy, pend
    );

    modport slave (
        input  l_req, r_req, en, clr,
        output key_a, key_b, busy, pend
    );
endinterface

// File: rtl/quad_phase_timer.sv
// Loadable down-counter that stops at zero; o_zero_c flags the expiry cycle.
module quad_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/quad_gen.sv
// Quadrature A/B generator: turns queued left/right step requests into
// paced Gray-code steps that always come to rest at 00 or 11.
module quad_gen
    import quad_pkg::*;
#(
    parameter int unsigned PHASE_CYC = PHASE_CYC_DEFAULT,
    parameter int unsigned PEND_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    quad_if.slave qif
);

    localparam int unsigned TMR_W = $clog2(PHASE_CYC + 1);
    localparam int unsigned EXT_W = PEND_W + 2;
    localparam logic signed [EXT_W-1:0] P_MAX = EXT_W'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] P_MIN = -P_MAX;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic                     r_dir;
    logic                     r_key_a;
    logic                     r_key_b;
    logic                     r_busy;
    logic signed [PEND_W-1:0] r_pend;

    logic                     w_go;
    logic                     w_dir_new;
    logic                     w_start;
    logic                     w_second;
    logic                     w_tmr_zero;
    logic                     w_tgl_a;
    logic                     w_tgl_b;
    logic signed [2:0]        w_delta;
    logic signed [EXT_W-1:0]  w_sum;
    logic signed [PEND_W-1:0] w_pend_nx;

    assign w_go      = qif.en && (r_pend != '0) && !qif.clr;
    assign w_dir_new = r_pend[PEND_W-1] ? DIR_L : DIR_R;

    quad_phase_timer #(
        .W (TMR_W)
    ) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start || w_second),
        .i_load_val (TMR_W'(PHASE_CYC - 1)),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state; a step may chain straight from the end of PH2
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_second   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_PH1;
                end
            end
            ST_PH1: begin
                if (w_tmr_zero) begin
                    w_second   = 1'b1;
                    w_state_nx = ST_PH2;
                end
            end
            ST_PH2: begin
                if (w_tmr_zero) begin
                    if (w_go) begin
                        w_start    = 1'b1;
                        w_state_nx = ST_PH1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Right steps lead with A, left steps lead with B
    assign w_tgl_a = (w_start && (w_dir_new == DIR_R)) || (w_second && (r_dir == DIR_L));
    assign w_tgl_b = (w_start && (w_dir_new == DIR_L)) || (w_second && (r_dir == DIR_R));

    // Net requests and the consumed step, then clamp symmetrically
    always_comb begin
        w_delta = 3'sd0;
        if (qif.r_req) w_delta = w_delta + 3'sd1;
        if (qif.l_req) w_delta = w_delta - 3'sd1;
        if (w_start)   w_delta = (w_dir_new == DIR_R) ? w_delta - 3'sd1 : w_delta + 3'sd1;
        w_sum = EXT_W'(r_pend) + EXT_W'(w_delta);
        if (w_sum > P_MAX) begin
            w_sum = P_MAX;
        end else if (w_sum < P_MIN) begin
            w_sum = P_MIN;
        end
        w_pend_nx = PEND_W'(w_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_a <= 1'b0;
            r_key_b <= 1'b0;
            r_busy  <= 1'b0;
            r_pend  <= '0;
            r_dir   <= DIR_R;
        end else begin
            r_busy <= (w_state_nx != ST_IDLE);
            r_pend <= qif.clr ? '0 : w_pend_nx;
            if (w_start) r_dir   <= w_dir_new;
            if (w_tgl_a) r_key_a <= ~r_key_a;
            if (w_tgl_b) r_key_b <= ~r_key_b;
        end
    end

    assign qif.key_a = r_key_a;
    assign qif.key_b = r_key_b;
    assign qif.busy  = r_busy;
    assign qif.pend  = r_pend;

endmodule

// File: tb/tb_quad_gen.sv
// Directed and random stimulus for quad_gen, checked against an event-time model.
module tb_quad_gen;

    localparam int PH   = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << (PW - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    quad_if #(.PEND_W(PW)) qif ();

    quad_gen #(
        .PHASE_CYC (PH),
        .PEND_W    (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .qif   (qif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a step started at decision edge T toggles its lead line after T,
    // its trailing line after T+PH, keeps busy through cycle T+2*PH and lets
    // the next step be decided at edge T+2*PH or later.
    int   k         = 0;
    int   free_at   = 0;
    int   sec_edge  = -1;
    int   busy_last = -1;
    bit   sec_a     = 1'b0;
    int   m_pend    = 0;
    logic m_a       = 1'b0;
    logic m_b       = 1'b0;
    logic m_busy    = 1'b0;

    // Edge-on-A decoder watching the DUT lines
    logic prev_a = 1'b0;
    int   dec_r  = 0;
    int   dec_l  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] pe;
        pe = m_pend[3:0];
        chk("key_a", {31'd0, qif.key_a}, {31'd0, m_a});
        chk("key_b", {31'd0, qif.key_b}, {31'd0, m_b});
        chk("busy",  {31'd0, qif.busy},  {31'd0, m_busy});
        chk("pend",  {28'd0, qif.pend},  {28'd0, pe});
    endtask

    task automatic tick(input logic li, input logic ri, input logic ei, input logic ci);
        bit start;
        int sgn;
        qif.l_req = li;
        qif.r_req = ri;
        qif.en    = ei;
        qif.clr   = ci;
        @(posedge clk);
        start = (k >= free_at) && ei && (m_pend != 0) && !ci;
        sgn   = (m_pend > 0) ? 1 : -1;
        if (start) begin
            if (sgn > 0) m_a = ~m_a;
            else         m_b = ~m_b;
            sec_a     = (sgn < 0);
            sec_edge  = k + PH;
            free_at   = k + 2 * PH;
            busy_last = k + 2 * PH;
        end else if (k == sec_edge) begin
            if (sec_a) m_a = ~m_a;
            else       m_b = ~m_b;
        end
        if (ci) begin
            m_pend = 0;
        end else begin
            m_pend = m_pend + int'(ri) - int'(li) - (start ? sgn : 0);
            if (m_pend > PMAX)  m_pend = PMAX;
            if (m_pend < -PMAX) m_pend = -PMAX;
        end
        m_busy = (k < busy_last);
        k++;
        #1;
        check_all();
        if (qif.key_a !== prev_a) begin
            if (qif.key_a != qif.key_b) dec_r++;
            else                        dec_l++;
        end
        prev_a = qif.key_a;
    endtask

    task automatic idle(input int n, input logic ei);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, ei, 1'b0);
    endtask

    initial begin
        int r0;
        int l0;
        logic a0;
        qif.l_req = 1'b0;
        qif.r_req = 1'b0;
        qif.en    = 1'b0;
        qif.clr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single right step from rest 00
        idle(9, 1'b1);
        r0 = dec_r; l0 = dec_l;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("t1_dec_r", 32'(dec_r - r0), 32'd1);
        chk("t1_dec_l", 32'(dec_l - l0), 32'd0);

        // 2: three left steps from rest 11, chained without gaps
        r0 = dec_r; l0 = dec_l;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        idle(30, 1'b1);
        chk("t2_dec_l", 32'(dec_l - l0), 32'd3);
        chk("t2_dec_r", 32'(dec_r - r0), 32'd0);
        chk("t2_rest",  {30'd0, qif.key_a, qif.key_b}, 32'd0);

        // 3: simultaneous requests cancel; then net one right
        r0 = dec_r; l0 = dec_l;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);
        chk("t3_nop", 32'(dec_r + dec_l - r0 - l0), 32'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        idle(24, 1'b1);
        chk("t3_dec_r", 32'(dec_r - r0), 32'd1);
        chk("t3_dec_l", 32'(dec_l - l0), 32'd0);

        // 4: saturation with en low, then drain
        a0 = qif.key_a;
        r0 = dec_r;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        chk("t4_sat", {28'd0, qif.pend}, 32'd7);
        idle(70, 1'b1);
        chk("t4_dec_r", 32'(dec_r - r0), 32'd7);
        chk("t4_rest",  {30'd0, qif.key_a, qif.key_b}, {30'd0, ~a0, ~a0});

        // 5: clr during the first step's PH1
        r0 = dec_r;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        idle(16, 1'b1);
        chk("t5_dec_r", 32'(dec_r - r0), 32'd1);
        chk("t5_rest",  {31'd0, qif.key_a}, {31'd0, qif.key_b});

        // Reset in the middle of a step forces lines low at once
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        m_a = 1'b0; m_b = 1'b0; m_busy = 1'b0; m_pend = 0;
        sec_edge = -1; busy_last = -1; free_at = k;
        check_all();
        @(negedge clk);
        rst_n  = 1'b1;
        prev_a = 1'b0;

        // Random traffic, then drain and compare decoder counts to the model
        r0 = dec_r; l0 = dec_l;
        begin
            int st_r;
            int st_l;
            int pk;
            st_r = 0; st_l = 0;
            for (int i = 0; i < 500; i++) begin
                pk = k;
                tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 49) == 0));
                if (free_at == pk + 2 * PH) begin
                    if (sec_a) st_l++;
                    else       st_r++;
                end
            end
            for (int i = 0; i < 120; i++) begin
                pk = k;
                tick(1'b0, 1'b0, 1'b1, 1'b0);
                if (free_at == pk + 2 * PH) begin
                    if (sec_a) st_l++;
                    else       st_r++;
                end
            end
            chk("rnd_dec_r", 32'(dec_r - r0), 32'(st_r));
            chk("rnd_dec_l", 32'(dec_l - l0), 32'(st_l));
            chk("rnd_rest",  {31'd0, qif.key_a}, {31'd0, qif.key_b});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
